memory_address_register: RTL and testbench



---
 rtl/memory_address_register.sv | 24 ++
 tb/tb_memory_address_register.sv | 122 ++++++++++++
 2 files changed

// File: rtl/memory_address_register.sv
// 4-bit memory address register for the small CPU datapath.
// Captures in_address when i_debug is high; synchronous reset clears it.
module memory_address_register (
  input  logic       enable_in,
  input  logic       reset,
  input  logic       i_debug,
  input  logic [3:0] in_address,
  output logic [3:0] out_address
);

  logic [3:0] addr_q;

  // Address register: reset beats load, load beats hold.
  always_ff @(posedge enable_in) begin
    if (reset) begin
      addr_q <= 4'b0000;
    end else if (i_debug) begin
      addr_q <= in_address;
    end
  end

  assign out_address = addr_q;

endmodule

// File: tb/tb_memory_address_register.sv
// Directed bench for memory_address_register.
// Inputs change 1 time unit after a rising edge; outputs sampled there.
module tb_memory_address_register;

  logic       clk;
  logic       reset;
  logic       i_debug;
  logic [3:0] in_address;
  logic [3:0] out_address;

  int tests;
  int failed;

  memory_address_register dut (
    .enable_in  (clk),
    .reset      (reset),
    .i_debug    (i_debug),
    .in_address (in_address),
    .out_address(out_address)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    tests++;
    assert (out_address === exp) else begin
      failed++;
      $error("FAIL %s: out_address=%b expected=%b", tag, out_address, exp);
    end
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    reset      = 1'b1;
    i_debug    = 1'b0;
    in_address = 4'b0000;

    tick();
    check("reset_init", 4'b0000);

    reset      = 1'b0;
    i_debug    = 1'b1;
    in_address = 4'b0100;
    tick();
    check("load_0100", 4'b0100);

    reset      = 1'b1;
    i_debug    = 1'b1;
    in_address = 4'b0100;
    tick();
    check("rst_prio_e1", 4'b0000);
    tick();
    check("rst_prio_e2", 4'b0000);

    reset      = 1'b0;
    i_debug    = 1'b0;
    in_address = 4'b1111;
    tick();
    check("hold_e1", 4'b0000);
    tick();
    check("hold_e2", 4'b0000);

    i_debug    = 1'b1;
    in_address = 4'b1111;
    tick();
    check("load_1111", 4'b1111);

    i_debug    = 1'b0;
    in_address = 4'b0010;
    tick();
    check("hold_1111_e1", 4'b1111);
    tick();
    check("hold_1111_e2", 4'b1111);

    i_debug    = 1'b1;
    in_address = 4'b1010;
    tick();
    check("load_1010", 4'b1010);

    #5;
    reset = 1'b1;
    #1;
    check("rst_midcycle", 4'b1010);
    tick();
    check("rst_at_edge", 4'b0000);

    reset      = 1'b0;
    i_debug    = 1'b1;
    in_address = 4'b0011;
    tick();
    check("load_0011", 4'b0011);

    #4;
    in_address = 4'b0101;
    #1;
    check("addr_midcycle", 4'b0011);
    tick();
    check("addr_at_edge", 4'b0101);

    for (int i = 0; i < 16; i++) begin
      in_address = 4'(i);
      tick();
      check($sformatf("sweep_%0d", i), 4'(i));
    end

    i_debug    = 1'b0;
    in_address = 4'b0110;
    tick();
    check("hold_after_sweep", 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
